// File: rtl/qbert_sysid_pkg.sv
// Shared types and constants for the sysid checker: FSM state encoding,
// sysid word addresses and data width.
package qbert_sysid_pkg;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_REQ_ID  = 3'd1,
    ST_WAIT_ID = 3'd2,
    ST_REQ_TS  = 3'd3,
    ST_WAIT_TS = 3'd4,
    ST_CMP     = 3'd5
  } state_t;

  localparam logic SYSID_ADDR_ID = 1'b0;
  localparam logic SYSID_ADDR_TS = 1'b1;
  localparam int   SYSID_DW      = 32;

endpackage

// File: rtl/qbert_only_sysid_checker.sv
// Avalon-MM read sequencer that reads the sysid ID and timestamp words, compares them
// with build-time values and retries on mismatch. QBERT_SYSID_CHECK_TIMEOUT_EN adds a stall watchdog.
module qbert_only_sysid_checker
  import qbert_sysid_pkg::*;
#(
  parameter logic [31:0] EXPECTED_ID  = 32'h56FAA292,
  parameter logic [31:0] EXPECTED_TS  = 32'h5A2F1C00,
  parameter int unsigned READ_LATENCY = 0,
  parameter int unsigned MAX_RETRIES  = 2,
  parameter bit          AUTO_START   = 1'b1
) (
  input  logic                clock,
  input  logic                reset_n,
  input  logic                start,
  output logic                avm_address,
  output logic                avm_read,
  input  logic                avm_waitrequest,
  input  logic [SYSID_DW-1:0] avm_readdata,
  output logic                busy,
  output logic                done,
  output logic                match,
  output logic                fail,
  output logic [SYSID_DW-1:0] read_id,
  output state_t              dbg_state,
  output logic [SYSID_DW-1:0] read_ts
`ifdef QBERT_SYSID_CHECK_TIMEOUT_EN
  ,
  output logic                timeout
`endif
);

  localparam bit         ZERO_LAT = (READ_LATENCY == 0);
  localparam logic [2:0] LAT_LOAD = ZERO_LAT ? 3'd0 : 3'(READ_LATENCY - 1);
  localparam logic [3:0] RETRY_MAX = 4'(MAX_RETRIES);

  state_t              state_q, state_d;
  logic [2:0]          lat_q, lat_d;
  logic [3:0]          retry_q, retry_d;
  logic                auto_q, auto_d;
  logic                done_q, done_d;
  logic                match_q, match_d;
  logic                fail_q, fail_d;
  logic [SYSID_DW-1:0] id_q, id_d;
  logic [SYSID_DW-1:0] ts_q, ts_d;
`ifdef QBERT_SYSID_CHECK_TIMEOUT_EN
  logic [7:0]          wd_q, wd_d;
  logic                timeout_q, timeout_d;
`endif

  // Handshake: a read is offered while avm_read=1 and accepted in the first cycle
  // avm_waitrequest=0; address and read are held steady until that cycle.
  always_comb begin
    state_d   = state_q;
    lat_d     = lat_q;
    retry_d   = retry_q;
    auto_d    = auto_q;
    done_d    = 1'b0;
    match_d   = match_q;
    fail_d    = fail_q;
    id_d      = id_q;
    ts_d      = ts_q;
`ifdef QBERT_SYSID_CHECK_TIMEOUT_EN
    wd_d      = wd_q;
    timeout_d = timeout_q;
`endif
    case (state_q)
      ST_IDLE: begin
        if (start || auto_q) begin
          auto_d  = 1'b0;
          retry_d = 4'd0;
          match_d = 1'b0;
          fail_d  = 1'b0;
`ifdef QBERT_SYSID_CHECK_TIMEOUT_EN
          timeout_d = 1'b0;
`endif
          state_d = ST_REQ_ID;
        end
      end
      ST_REQ_ID, ST_REQ_TS: begin
        if (!avm_waitrequest) begin
`ifdef QBERT_SYSID_CHECK_TIMEOUT_EN
          wd_d = 8'd0;
`endif
          if (ZERO_LAT) begin
            if (state_q == ST_REQ_ID) begin
              id_d    = avm_readdata;
              state_d = ST_REQ_TS;
            end else begin
              ts_d    = avm_readdata;
              state_d = ST_CMP;
            end
          end else begin
            lat_d   = LAT_LOAD;
            state_d = (state_q == ST_REQ_ID) ? ST_WAIT_ID : ST_WAIT_TS;
          end
        end
`ifdef QBERT_SYSID_CHECK_TIMEOUT_EN
        else if (wd_q == 8'd254) begin
          // 255th consecutive stall: give up without retrying.
          wd_d      = 8'd0;
          fail_d    = 1'b1;
          timeout_d = 1'b1;
          done_d    = 1'b1;
          state_d   = ST_IDLE;
        end else begin
          wd_d = wd_q + 8'd1;
        end
`endif
      end
      ST_WAIT_ID: begin
        if (lat_q == 3'd0) begin
          id_d    = avm_readdata;
          state_d = ST_REQ_TS;
        end else begin
          lat_d = lat_q - 3'd1;
        end
      end
      ST_WAIT_TS: begin
        if (lat_q == 3'd0) begin
          ts_d    = avm_readdata;
          state_d = ST_CMP;
        end else begin
          lat_d = lat_q - 3'd1;
        end
      end
      ST_CMP: begin
        if ((id_q == EXPECTED_ID) && (ts_q == EXPECTED_TS)) begin
          match_d = 1'b1;
          done_d  = 1'b1;
          state_d = ST_IDLE;
        end else if (retry_q < RETRY_MAX) begin
          retry_d = retry_q + 4'd1;
          state_d = ST_REQ_ID;
        end else begin
          fail_d  = 1'b1;
          done_d  = 1'b1;
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q   <= ST_IDLE;
      lat_q     <= 3'd0;
      retry_q   <= 4'd0;
      auto_q    <= AUTO_START;
      done_q    <= 1'b0;
      match_q   <= 1'b0;
      fail_q    <= 1'b0;
      id_q      <= '0;
      ts_q      <= '0;
`ifdef QBERT_SYSID_CHECK_TIMEOUT_EN
      wd_q      <= 8'd0;
      timeout_q <= 1'b0;
`endif
    end else begin
      state_q   <= state_d;
      lat_q     <= lat_d;
      retry_q   <= retry_d;
      auto_q    <= auto_d;
      done_q    <= done_d;
      match_q   <= match_d;
      fail_q    <= fail_d;
      id_q      <= id_d;
      ts_q      <= ts_d;
`ifdef QBERT_SYSID_CHECK_TIMEOUT_EN
      wd_q      <= wd_d;
      timeout_q <= timeout_d;
`endif
    end
  end

  // Address stays on the word being fetched through its latency wait.
  assign avm_read    = (state_q == ST_REQ_ID) || (state_q == ST_REQ_TS);
  assign avm_address = ((state_q == ST_REQ_TS) || (state_q == ST_WAIT_TS)) ? SYSID_ADDR_TS
                                                                          : SYSID_ADDR_ID;
  assign busy        = (state_q != ST_IDLE);
  assign done        = done_q;
  assign match       = match_q;
  assign fail        = fail_q;
  assign read_id     = id_q;
  assign read_ts     = ts_q;
  assign dbg_state   = state_q;
`ifdef QBERT_SYSID_CHECK_TIMEOUT_EN
  assign timeout     = timeout_q;
`endif

endmodule
